// File: rtl/phase_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// phase_seq_pkg
// Shared definitions for the N-phase machine-clock sequencer.
//   ST_IDLE / ST_RUN / ST_DRAIN : FSM state encoding (2 bits)
//   MAX_PHASES / MAX_IDX_W      : widest supported phase vector and index
//   idx_width(n)                : phase index width, never below 1 bit
//   onehot(idx, n)              : one-hot vector of idx, bits at or above n cleared
// ---------------------------------------------------------------------------
package phase_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int MAX_PHASES = 16;
  localparam int MAX_IDX_W  = 4;

  // A 2-phase machine still needs a 1-bit index; $clog2(2) alone would
  // be fine, but $clog2(1) would not, so clamp explicitly.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_PHASES-1:0] onehot(input logic [MAX_IDX_W-1:0] idx,
                                                   input int n);
    logic [MAX_PHASES-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_PHASES; i++) begin
      if ((i < n) && (idx == MAX_IDX_W'(i))) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/phase_sequencer_step_edge_detect.sv
// ---------------------------------------------------------------------------
// step_edge_detect
// One-flop rising-edge detector for the front-panel Step input.
//   Cin        in  clock
//   Reset      in  synchronous active-high reset
//   Step       in  raw step level
//   step_pulse out Step & ~Step_q (combinational)
// The history flop resets to 1, so a Step already held high when reset
// releases is treated as "seen" and never yields a pulse.
// ---------------------------------------------------------------------------
module step_edge_detect (
  input  logic Cin,
  input  logic Reset,
  input  logic Step,
  output logic step_pulse
);

  logic r_step_q;

  always_ff @(posedge Cin) begin
    if (Reset) r_step_q <= 1'b1;
    else       r_step_q <= Step;
  end

  assign step_pulse = Step & ~r_step_q;

endmodule

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
// N-phase non-overlapping machine-clock sequencer with free run, graceful
// stop at a cycle boundary and single-step.
//   Cin          in  sole clock, all state on posedge
//   Reset        in  synchronous active-high reset, dominates everything
//   Run          in  level: 1 free-run, 0 stop at next cycle boundary
//   Step         in  rising edge while stopped advances one phase
//   Phase_Out    out registered phase vector (bit i = phase i)
//   Phase_Idx    out current phase index 0..NUM_PHASES-1
//   Cycle_End    out one-cycle pulse on the NUM_PHASES-1 -> 0 wrap
//   Halted       out registered (next state == IDLE)
//   Cycle_Count  out completed machine cycles, wraps silently
//   Dbg_State    out current FSM state (ST_IDLE/ST_RUN/ST_DRAIN)
// NUM_PHASES is legal from 2 to 16.
// ---------------------------------------------------------------------------
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES    = 3,
  parameter int CNT_W         = 16,
  parameter int IDLE_ALL_HIGH = 1,
  localparam int IDX_W        = idx_width(NUM_PHASES)
) (
  input  logic                  Cin,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic                  Step,
  output logic [NUM_PHASES-1:0] Phase_Out,
  output logic [IDX_W-1:0]      Phase_Idx,
  output logic                  Cycle_End,
  output logic                  Halted,
  output logic [CNT_W-1:0]      Cycle_Count,
  output logic [1:0]            Dbg_State
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_next;
  logic                  w_advance;
  logic                  w_wrap;
  logic                  w_step_pulse;
  logic                  w_hold_all_high;
  logic [NUM_PHASES-1:0] w_phase_next;
  logic [NUM_PHASES-1:0] r_phase_out;
  logic                  r_cycle_end;
  logic                  r_halted;
  logic [CNT_W-1:0]      r_count;

  step_edge_detect u_step_edge (
    .Cin        (Cin),
    .Reset      (Reset),
    .Step       (Step),
    .step_pulse (w_step_pulse)
  );

  // State register.
  always_ff @(posedge Cin) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state plus the advance decision. Leaving RUN or DRAIN always
  // advances, so the stop lands exactly on the wrap to index 0.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Run) begin
          w_state_next = ST_RUN;
          w_advance    = 1'b1;
        end else if (w_step_pulse) begin
          w_advance    = 1'b1;
        end
      end
      ST_RUN: begin
        w_advance = 1'b1;
        if (!Run) w_state_next = (r_idx == LAST_IDX) ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        w_advance = 1'b1;
        if (Run)                   w_state_next = ST_RUN;
        else if (r_idx == LAST_IDX) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output / datapath next values.
  // All-ones is shown only while parked in IDLE at index 0 with no advance;
  // the edge that arrives at index 0 (stop wrap or step wrap) still shows
  // the one-hot phase 0 for one cycle.
  always_comb begin
    w_wrap          = w_advance && (r_idx == LAST_IDX);
    w_idx_next      = r_idx;
    if (w_advance) w_idx_next = w_wrap ? '0 : r_idx + IDX_W'(1);
    w_hold_all_high = (IDLE_ALL_HIGH != 0) && (r_state == ST_IDLE) &&
                      (w_state_next == ST_IDLE) && !w_advance && (r_idx == '0);
    w_phase_next    = w_hold_all_high ? '1 :
                      NUM_PHASES'(onehot(MAX_IDX_W'(w_idx_next), NUM_PHASES));
  end

  always_ff @(posedge Cin) begin
    if (Reset) begin
      r_idx       <= '0;
      r_phase_out <= NUM_PHASES'(1);
      r_cycle_end <= 1'b0;
      r_halted    <= 1'b1;
      r_count     <= '0;
    end else begin
      r_idx       <= w_idx_next;
      r_phase_out <= w_phase_next;
      r_cycle_end <= w_wrap;
      r_halted    <= (w_state_next == ST_IDLE);
      if (w_wrap) r_count <= r_count + CNT_W'(1);
    end
  end

  assign Phase_Out   = r_phase_out;
  assign Phase_Idx   = r_idx;
  assign Cycle_End   = r_cycle_end;
  assign Halted      = r_halted;
  assign Cycle_Count = r_count;
  assign Dbg_State   = r_state;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

  logic       Cin;
  // 3-phase instance
  logic       Reset, Run, Step;
  logic [2:0] Phase_Out;
  logic [1:0] Phase_Idx;
  logic       Cycle_End, Halted;
  logic [3:0] Cycle_Count;
  logic [1:0] Dbg_State;
  // 5-phase instance
  logic       p5_reset, p5_run, p5_step;
  logic [4:0] p5_phase_out;
  logic [2:0] p5_phase_idx;
  logic       p5_cycle_end, p5_halted;
  logic [1:0] p5_cycle_count;
  logic [1:0] p5_dbg_state;

  int errors = 0;
  int checks = 0;

  phase_sequencer #(.NUM_PHASES(3), .CNT_W(4), .IDLE_ALL_HIGH(1)) u_dut (
    .Cin(Cin), .Reset(Reset), .Run(Run), .Step(Step),
    .Phase_Out(Phase_Out), .Phase_Idx(Phase_Idx), .Cycle_End(Cycle_End),
    .Halted(Halted), .Cycle_Count(Cycle_Count), .Dbg_State(Dbg_State)
  );

  phase_sequencer #(.NUM_PHASES(5), .CNT_W(2), .IDLE_ALL_HIGH(0)) u_p5 (
    .Cin(Cin), .Reset(p5_reset), .Run(p5_run), .Step(p5_step),
    .Phase_Out(p5_phase_out), .Phase_Idx(p5_phase_idx), .Cycle_End(p5_cycle_end),
    .Halted(p5_halted), .Cycle_Count(p5_cycle_count), .Dbg_State(p5_dbg_state)
  );

  // clock / reset block
  initial Cin = 1'b0;
  always #5 Cin = ~Cin;

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick;
    @(posedge Cin);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Run = 1'b0; Step = 1'b0;
    tick(); tick();
    checks++; if (Phase_Out !== 3'b001) begin errors++; $display("FAIL reset_phase_out: got %b want 001", Phase_Out); end
    checks++; if (Phase_Idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", Phase_Idx); end
    checks++; if (Cycle_End !== 1'b0) begin errors++; $display("FAIL reset_cycle_end: got %b want 0", Cycle_End); end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b want 1", Halted); end
    checks++; if (Cycle_Count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", Cycle_Count); end
    checks++; if (Dbg_State !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", Dbg_State); end
  endtask

  // Run high through the last reset edge, then six free-running edges.
  task automatic test_run;
    logic [2:0] exp_po [6];
    logic       exp_ce [6];
    exp_po = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    exp_ce = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    Run = 1'b1;
    tick();
    checks++; if (Phase_Out !== 3'b001) begin errors++; $display("FAIL run_first: got %b want 001", Phase_Out); end
    Reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (Phase_Out !== exp_po[k]) begin errors++; $display("FAIL run_phase[%0d]: got %b want %b", k, Phase_Out, exp_po[k]); end
      checks++; if (Cycle_End !== exp_ce[k]) begin errors++; $display("FAIL run_cycle_end[%0d]: got %b want %b", k, Cycle_End, exp_ce[k]); end
    end
    checks++; if (Cycle_Count !== 4'd2) begin errors++; $display("FAIL run_count: got %0d want 2", Cycle_Count); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL run_halted: got %b want 0", Halted); end
  endtask

  // Run drops with index 1: one more phase, then 001 halted, then 111.
  task automatic test_stop;
    tick();
    checks++; if (Phase_Idx !== 2'd1) begin errors++; $display("FAIL stop_pre_idx: got %0d want 1", Phase_Idx); end
    Run = 1'b0;
    tick();
    checks++; if (Phase_Out !== 3'b100) begin errors++; $display("FAIL stop_drain_phase: got %b want 100", Phase_Out); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL stop_drain_halted: got %b want 0", Halted); end
    checks++; if (Dbg_State !== 2'd2) begin errors++; $display("FAIL stop_drain_state: got %0d want 2", Dbg_State); end
    tick();
    checks++; if (Phase_Out !== 3'b001) begin errors++; $display("FAIL stop_wrap_phase: got %b want 001", Phase_Out); end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL stop_wrap_halted: got %b want 1", Halted); end
    checks++; if (Cycle_End !== 1'b1) begin errors++; $display("FAIL stop_wrap_cycle_end: got %b want 1", Cycle_End); end
    checks++; if (Cycle_Count !== 4'd3) begin errors++; $display("FAIL stop_count: got %0d want 3", Cycle_Count); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (Phase_Out !== 3'b111) begin errors++; $display("FAIL stop_idle_phase[%0d]: got %b want 111", k, Phase_Out); end
    end
    checks++; if (Cycle_End !== 1'b0) begin errors++; $display("FAIL stop_idle_cycle_end: got %b want 0", Cycle_End); end
  endtask

  // Three step pulses two clocks apart, then Step held high.
  task automatic test_step;
    logic [2:0] exp_po [3];
    logic       exp_ce [3];
    exp_po = '{3'b010, 3'b100, 3'b001};
    exp_ce = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      Step = 1'b1;
      tick();
      checks++; if (Phase_Out !== exp_po[k]) begin errors++; $display("FAIL step_phase[%0d]: got %b want %b", k, Phase_Out, exp_po[k]); end
      checks++; if (Cycle_End !== exp_ce[k]) begin errors++; $display("FAIL step_cycle_end[%0d]: got %b want %b", k, Cycle_End, exp_ce[k]); end
      checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL step_halted[%0d]: got %b want 1", k, Halted); end
      if (k < 2) Step = 1'b0;
      tick();
    end
    // Step stayed high since the third pulse: parked at 0 showing 111.
    checks++; if (Phase_Out !== 3'b111) begin errors++; $display("FAIL step_after_wrap: got %b want 111", Phase_Out); end
    for (int k = 0; k < 3; k++) tick();
    checks++; if (Phase_Idx !== 2'd0) begin errors++; $display("FAIL step_held_idx: got %0d want 0", Phase_Idx); end
    checks++; if (Cycle_Count !== 4'd4) begin errors++; $display("FAIL step_count: got %0d want 4", Cycle_Count); end
    Step = 1'b0;
    tick();
  endtask

  // Run and Step rise together in IDLE; later Run re-raised during DRAIN.
  task automatic test_back_to_back;
    logic [2:0] exp_po [8];
    logic       run_v  [8];
    logic [1:0] exp_st [8];
    Run = 1'b1; Step = 1'b1;
    tick();
    checks++; if (Phase_Out !== 3'b010) begin errors++; $display("FAIL same_edge_phase: got %b want 010", Phase_Out); end
    checks++; if (Dbg_State !== 2'd1) begin errors++; $display("FAIL same_edge_state: got %0d want 1", Dbg_State); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL same_edge_halted: got %b want 0", Halted); end
    Step = 1'b0;
    // Run value applied before each edge, and expected result of that edge.
    run_v  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_po = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    exp_st = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    for (int k = 0; k < 8; k++) begin
      Run = run_v[k];
      tick();
      checks++; if (Phase_Out !== exp_po[k]) begin errors++; $display("FAIL drain_rerun_phase[%0d]: got %b want %b", k, Phase_Out, exp_po[k]); end
      checks++; if (Dbg_State !== exp_st[k]) begin errors++; $display("FAIL drain_rerun_state[%0d]: got %0d want %0d", k, Dbg_State, exp_st[k]); end
    end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL drain_rerun_halted: got %b want 1", Halted); end
    checks++; if (Cycle_Count !== 4'd7) begin errors++; $display("FAIL drain_rerun_count: got %0d want 7", Cycle_Count); end
  endtask

  // Reset while running at index 2 (the edge would otherwise wrap).
  task automatic test_reset_mid;
    Run = 1'b1;
    tick(); tick();
    checks++; if (Phase_Idx !== 2'd2) begin errors++; $display("FAIL mid_pre_idx: got %0d want 2", Phase_Idx); end
    Reset = 1'b1;
    tick();
    checks++; if (Phase_Out !== 3'b001) begin errors++; $display("FAIL mid_phase: got %b want 001", Phase_Out); end
    checks++; if (Cycle_Count !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", Cycle_Count); end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL mid_halted: got %b want 1", Halted); end
    checks++; if (Cycle_End !== 1'b0) begin errors++; $display("FAIL mid_cycle_end: got %b want 0", Cycle_End); end
    Reset = 1'b0; Run = 1'b0;
    tick();
  endtask

  // 5 phases, 2-bit counter, idle shows phase 0 one-hot.
  task automatic test_five_phase;
    logic [4:0] exp_po;
    logic       exp_ce;
    logic [1:0] exp_cnt;
    p5_reset = 1'b1; p5_run = 1'b1; p5_step = 1'b0;
    tick();
    checks++; if (p5_phase_out !== 5'b00001) begin errors++; $display("FAIL p5_reset_phase: got %b want 00001", p5_phase_out); end
    p5_reset = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      tick();
      exp_po  = 5'b00001 << (k % 5);
      exp_ce  = ((k % 5) == 0);
      exp_cnt = 2'((k / 5) % 4);
      checks++; if (p5_phase_out !== exp_po) begin errors++; $display("FAIL p5_phase[%0d]: got %b want %b", k, p5_phase_out, exp_po); end
      checks++; if (p5_cycle_end !== exp_ce) begin errors++; $display("FAIL p5_cycle_end[%0d]: got %b want %b", k, p5_cycle_end, exp_ce); end
      checks++; if (p5_cycle_count !== exp_cnt) begin errors++; $display("FAIL p5_count[%0d]: got %0d want %0d", k, p5_cycle_count, exp_cnt); end
    end
    // Index 1 now; stopping takes four more edges to reach the wrap.
    p5_run = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checks++; if (p5_phase_out !== 5'b00001) begin errors++; $display("FAIL p5_stop_phase: got %b want 00001", p5_phase_out); end
    checks++; if (p5_halted !== 1'b1) begin errors++; $display("FAIL p5_stop_halted: got %b want 1", p5_halted); end
    checks++; if (p5_cycle_count !== 2'd1) begin errors++; $display("FAIL p5_stop_count: got %0d want 1", p5_cycle_count); end
    tick(); tick();
    checks++; if (p5_phase_out !== 5'b00001) begin errors++; $display("FAIL p5_idle_phase: got %b want 00001", p5_phase_out); end
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Step = 1'b0;
    p5_reset = 1'b1; p5_run = 1'b0; p5_step = 1'b0;
    test_reset();
    test_run();
    test_stop();
    test_step();
    test_back_to_back();
    test_reset_mid();
    test_five_phase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
